// File: rtl/register_pipeline.sv
// Stallable, flushable fixed-latency delay line of DEPTH stages with an occupancy count.
// Define REGISTER_PIPELINE_DATA_RESET_EN to give the data registers an asynchronous reset.
module register_pipeline #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW = (DEPTH == 0) ? 1 : $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] in,
    input  logic             valid_in,
    output logic [WIDTH-1:0] out,
    output logic             valid_out,
    output logic [CW-1:0]    count
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_s;

            assign out       = in;
            assign valid_out = valid_in;
            assign count     = {CW{1'b0}};
            assign unused_s  = ^{clk, rst, en, flush};
        end else begin : g_pipe
            logic [WIDTH-1:0] data_r [DEPTH];
            logic [DEPTH-1:0] valid_r;
            logic [DEPTH-1:0] valid_nxt_s;
            logic [CW-1:0]    count_r;
            logic [CW-1:0]    count_nxt_s;

            // Next valid vector: flush wins over shifting, stall holds.
            always_comb begin
                valid_nxt_s = valid_r;
                if (flush) begin
                    valid_nxt_s = {DEPTH{1'b0}};
                end else if (en) begin
                    valid_nxt_s[0] = valid_in;
                    for (int i = 1; i < DEPTH; i++) begin
                        valid_nxt_s[i] = valid_r[i-1];
                    end
                end else begin
                    valid_nxt_s = valid_r;
                end
            end

            // Occupancy tracks the valid popcount: one in at stage 0, one out at the last stage.
            always_comb begin
                count_nxt_s = count_r;
                if (flush) begin
                    count_nxt_s = {CW{1'b0}};
                end else if (en) begin
                    count_nxt_s = count_r + CW'(valid_in) - CW'(valid_r[DEPTH-1]);
                end else begin
                    count_nxt_s = count_r;
                end
            end

            // Valid bits and count always carry an asynchronous reset.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_r <= {DEPTH{1'b0}};
                    count_r <= {CW{1'b0}};
                end else begin
                    valid_r <= valid_nxt_s;
                    count_r <= count_nxt_s;
                end
            end

`ifdef REGISTER_PIPELINE_DATA_RESET_EN
            // Data shift register, cleared on reset; words move regardless of validity.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        data_r[i] <= {WIDTH{1'b0}};
                    end
                end else if (en) begin
                    data_r[0] <= in;
                    for (int i = 1; i < DEPTH; i++) begin
                        data_r[i] <= data_r[i-1];
                    end
                end
            end
`else
            // Data shift register without reset; words move regardless of validity.
            always_ff @(posedge clk) begin
                if (en) begin
                    data_r[0] <= in;
                    for (int i = 1; i < DEPTH; i++) begin
                        data_r[i] <= data_r[i-1];
                    end
                end
            end
`endif

            assign out       = data_r[DEPTH-1];
            assign valid_out = valid_r[DEPTH-1];
            assign count     = count_r;
        end
    endgenerate

endmodule

// File: tb/tb_register_pipeline.sv
// Self-checking bench for register_pipeline: directed scenarios on DEPTH=4 plus a random
// run comparing DEPTH 4/1/0 instances against a queue scoreboard of in-flight words.
module tb_register_pipeline;

    typedef struct packed {
        logic [31:0] d;
        int          pos;
    } item_t;

    logic        clk;
    logic        rst;
    logic        en;
    logic        flush;
    logic        valid_in;
    logic [31:0] din;

    logic [7:0]  out4;
    logic        vo4;
    logic [2:0]  cnt4;
    logic [0:0]  out1;
    logic        vo1;
    logic [0:0]  cnt1;
    logic [31:0] out0;
    logic        vo0;
    logic [0:0]  cnt0;

    int checks   = 0;
    int failures = 0;

    item_t q4[$];
    item_t q1[$];

    register_pipeline #(.WIDTH(8), .DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .in(din[7:0]), .valid_in(valid_in),
        .out(out4), .valid_out(vo4), .count(cnt4)
    );

    register_pipeline #(.WIDTH(1), .DEPTH(1)) u_d1 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .in(din[0:0]), .valid_in(valid_in),
        .out(out1), .valid_out(vo1), .count(cnt1)
    );

    register_pipeline #(.WIDTH(32), .DEPTH(0)) u_d0 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .in(din), .valid_in(valid_in),
        .out(out0), .valid_out(vo0), .count(cnt0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance the scoreboard by one clock edge with the current inputs, then wait for the sample point.
    task automatic step();
        item_t tmp;
        if (en) begin
            if (q4.size() > 0 && q4[0].pos == 3) void'(q4.pop_front());
            for (int i = 0; i < q4.size(); i++) begin
                tmp = q4[i]; tmp.pos = tmp.pos + 1; q4[i] = tmp;
            end
            if (q1.size() > 0 && q1[0].pos == 0) void'(q1.pop_front());
            for (int i = 0; i < q1.size(); i++) begin
                tmp = q1[i]; tmp.pos = tmp.pos + 1; q1[i] = tmp;
            end
            if (valid_in && !flush) begin
                tmp.d = din; tmp.pos = 0;
                q4.push_back(tmp);
                q1.push_back(tmp);
            end
        end
        if (flush) begin
            q4.delete();
            q1.delete();
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        en = 1'b1; flush = 1'b0; valid_in = 1'b1; din = 32'h1;
        rst = 1'b0;
        #1 rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if (vo4 !== 1'b0) begin failures++; $display("FAIL reset_valid4: got %b expected 0", vo4); end
            checks++; if (cnt4 !== 3'd0) begin failures++; $display("FAIL reset_count4: got %0d expected 0", cnt4); end
            checks++; if (vo1 !== 1'b0) begin failures++; $display("FAIL reset_valid1: got %b expected 0", vo1); end
            checks++; if (cnt1 !== 1'd0) begin failures++; $display("FAIL reset_count1: got %0d expected 0", cnt1); end
`ifdef REGISTER_PIPELINE_DATA_RESET_EN
            checks++; if (out4 !== 8'h00) begin failures++; $display("FAIL reset_data4: got %0h expected 0", out4); end
`endif
        end
        en = 1'b0; valid_in = 1'b0; din = 32'h0;
        rst = 1'b0;
    endtask

    task automatic test_stream();
        int exp_cnt;
        en = 1'b1; valid_in = 1'b1;
        for (int j = 0; j < 10; j++) begin
            din = 32'h10 + 32'(j);
            step();
            exp_cnt = (j + 1 < 4) ? j + 1 : 4;
            checks++; if (int'(cnt4) !== exp_cnt) begin failures++; $display("FAIL stream_count: got %0d expected %0d", cnt4, exp_cnt); end
            checks++; if (vo4 !== (j >= 3)) begin failures++; $display("FAIL stream_valid: got %b expected %b", vo4, (j >= 3)); end
            if (j >= 3) begin
                checks++; if (out4 !== 8'(8'h10 + j - 3)) begin failures++; $display("FAIL stream_data: got %0h expected %0h", out4, 8'(8'h10 + j - 3)); end
            end
        end
    endtask

    task automatic test_stall();
        en = 1'b0; valid_in = 1'b1; din = 32'hEE;
        for (int j = 0; j < 3; j++) begin
            step();
            checks++; if (cnt4 !== 3'd4) begin failures++; $display("FAIL stall_count: got %0d expected 4", cnt4); end
            checks++; if (vo4 !== 1'b1) begin failures++; $display("FAIL stall_valid: got %b expected 1", vo4); end
            checks++; if (out4 !== 8'h16) begin failures++; $display("FAIL stall_data: got %0h expected 16", out4); end
        end
        en = 1'b1;
        for (int j = 0; j < 4; j++) begin
            din = 32'h1A + 32'(j);
            step();
            checks++; if (out4 !== 8'(8'h17 + j)) begin failures++; $display("FAIL stall_resume_data: got %0h expected %0h", out4, 8'(8'h17 + j)); end
            checks++; if (vo4 !== 1'b1) begin failures++; $display("FAIL stall_resume_valid: got %b expected 1", vo4); end
        end
    endtask

    task automatic test_flush();
        en = 1'b1; valid_in = 1'b1; flush = 1'b1; din = 32'hAA;
        step();
        flush = 1'b0; valid_in = 1'b0; din = 32'h0;
        checks++; if (cnt4 !== 3'd0) begin failures++; $display("FAIL flush_count: got %0d expected 0", cnt4); end
        checks++; if (vo4 !== 1'b0) begin failures++; $display("FAIL flush_valid: got %b expected 0", vo4); end
        for (int j = 0; j < 6; j++) begin
            step();
            checks++; if (vo4 !== 1'b0) begin failures++; $display("FAIL flush_drop: got valid=%b data=%0h expected valid=0", vo4, out4); end
        end
    endtask

    task automatic test_async_reset();
        en = 1'b1; valid_in = 1'b1;
        for (int j = 0; j < 3; j++) begin
            din = 32'h30 + 32'(j);
            step();
        end
        checks++; if (cnt4 !== 3'd3) begin failures++; $display("FAIL areset_pre_count: got %0d expected 3", cnt4); end
        #2 rst = 1'b1;
        #1;
        checks++; if (vo4 !== 1'b0) begin failures++; $display("FAIL areset_valid: got %b expected 0", vo4); end
        checks++; if (cnt4 !== 3'd0) begin failures++; $display("FAIL areset_count: got %0d expected 0", cnt4); end
        q4.delete();
        q1.delete();
        @(negedge clk);
        rst = 1'b0;
        din = 32'h55; valid_in = 1'b1; en = 1'b1;
        step();
        valid_in = 1'b0; din = 32'h0;
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) step();
            checks++; if (vo4 !== (k == 4)) begin failures++; $display("FAIL areset_latency: edge %0d got valid=%b expected %b", k, vo4, (k == 4)); end
            if (k == 4) begin
                checks++; if (out4 !== 8'h55) begin failures++; $display("FAIL areset_data: got %0h expected 55", out4); end
            end
        end
    endtask

    task automatic test_random();
        bit exp_v4;
        bit exp_v1;
        for (int n = 0; n < 10000; n++) begin
            en       = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 15) == 0);
            valid_in = $urandom_range(0, 1) == 1;
            din      = $urandom;
            #1;
            checks++; if (out0 !== din || vo0 !== valid_in || cnt0 !== 1'd0) begin
                failures++; $display("FAIL rand_wire: got %0h/%b/%0d expected %0h/%b/0", out0, vo0, cnt0, din, valid_in);
            end
            step();
            exp_v4 = (q4.size() > 0) && (q4[0].pos == 3);
            exp_v1 = (q1.size() > 0) && (q1[0].pos == 0);
            checks++; if (int'(cnt4) !== q4.size()) begin failures++; $display("FAIL rand_count4: cycle %0d got %0d expected %0d", n, cnt4, q4.size()); end
            checks++; if (vo4 !== exp_v4) begin failures++; $display("FAIL rand_valid4: cycle %0d got %b expected %b", n, vo4, exp_v4); end
            if (exp_v4) begin
                checks++; if (out4 !== q4[0].d[7:0]) begin failures++; $display("FAIL rand_data4: cycle %0d got %0h expected %0h", n, out4, q4[0].d[7:0]); end
            end
            checks++; if (int'(cnt1) !== q1.size()) begin failures++; $display("FAIL rand_count1: cycle %0d got %0d expected %0d", n, cnt1, q1.size()); end
            checks++; if (vo1 !== exp_v1) begin failures++; $display("FAIL rand_valid1: cycle %0d got %b expected %b", n, vo1, exp_v1); end
            if (exp_v1) begin
                checks++; if (out1 !== q1[0].d[0:0]) begin failures++; $display("FAIL rand_data1: cycle %0d got %b expected %b", n, out1, q1[0].d[0]); end
            end
        end
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
